// File: rtl/rpcsl_pkg.sv
// Shared types for the RP console-side mount sequencer.
package rpcsl_pkg;

  typedef enum logic [1:0] {
    OP_MOUNT   = 2'd0,
    OP_UNMOUNT = 2'd1,
    OP_WRL_SET = 2'd2,
    OP_WRL_CLR = 2'd3
  } rpcsl_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_SPINDN = 2'd2
  } rpcsl_st_t;

endpackage

// File: rtl/rpcsl_timer.sv
// Loadable down-counter shared by the spin-up and spin-down sequences; holds at zero.
module rpcsl_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] loadVal,
  output logic [TW-1:0] cnt,
  output logic          isZero_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign isZero_c = (cnt == '0);

endmodule

// File: rtl/rpcsl_mount_seq.sv
// Console-side sequencer for RP drive-status lines (DPR/MOL/WRL), one command at a time.
// Define RPCSL_DEBUG_EN to add the 64-bit rpDEBUG snapshot register.
module rpcsl_mount_seq
  import rpcsl_pkg::*;
#(
  parameter int unsigned NDRV       = 8,
  parameter int unsigned SPINUP_CYC = 1000,
  parameter int unsigned SPINDN_CYC = 100,
  parameter int unsigned TW         = 16,
  localparam int unsigned UW        = (NDRV > 1) ? $clog2(NDRV) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic [1:0]      cmd_op,
  input  logic [UW-1:0]   cmd_unit,
  output logic            cmd_done,
  output logic            cmd_err,
  output logic            busy,
  output logic [NDRV-1:0] rpDPR,
  output logic [NDRV-1:0] rpMOL,
  output logic [NDRV-1:0] rpWRL,
  input  logic [0:63]     rpDEBUG,
  input  logic            dbg_req,
  output logic            dbg_vld,
  output logic [0:63]     dbg_data
);

  rpcsl_st_t       state;
  rpcsl_op_t       op_c;
  logic [NDRV-1:0] curMask;
  logic [NDRV-1:0] unitMask_c;
  logic [NDRV-1:0] finMask_c;
  logic            unitOk_c;
  logic            accept_c;
  logic            mountOk_c;
  logic            unmountOk_c;
  logic            wrlOk_c;
  logic            reject_c;
  logic            finUp_c;
  logic            finDn_c;
  logic            tmrLoad_c;
  logic [TW-1:0]   tmrLoadVal_c;
  logic [TW-1:0]   tmrCnt;
  logic            tmrZero_c;

  assign op_c     = rpcsl_op_t'(cmd_op);
  assign accept_c = cmd_vld & cmd_rdy;

  // Out-of-range unit numbers only exist when NDRV is not a power of two
  if (NDRV == (1 << UW)) begin : g_unitFull
    assign unitOk_c = 1'b1;
  end else begin : g_unitPartial
    assign unitOk_c = (32'(cmd_unit) < NDRV);
  end

  assign unitMask_c = unitOk_c ? (NDRV'(1) << cmd_unit) : '0;

  always_comb begin
    mountOk_c   = 1'b0;
    unmountOk_c = 1'b0;
    wrlOk_c     = 1'b0;
    if (accept_c && unitOk_c) begin
      case (op_c)
        OP_MOUNT:   mountOk_c   = ~|(rpDPR & unitMask_c);
        OP_UNMOUNT: unmountOk_c = |(rpMOL & unitMask_c);
        OP_WRL_SET: wrlOk_c     = |(rpDPR & unitMask_c);
        OP_WRL_CLR: wrlOk_c     = |(rpDPR & unitMask_c);
      endcase
    end
  end

  assign reject_c     = accept_c & ~(mountOk_c | unmountOk_c | wrlOk_c);
  assign tmrLoad_c    = mountOk_c | unmountOk_c;
  assign tmrLoadVal_c = mountOk_c ? TW'(SPINUP_CYC - 1) : TW'(SPINDN_CYC - 1);

  // Completion is registered one edge early so it lands in the cycle the timer reads zero
  assign finUp_c   = (mountOk_c && (SPINUP_CYC == 1)) ||
                     ((state == ST_SPINUP) && (tmrCnt == TW'(1)));
  assign finDn_c   = (unmountOk_c && (SPINDN_CYC == 1)) ||
                     ((state == ST_SPINDN) && (tmrCnt == TW'(1)));
  assign finMask_c = (state == ST_IDLE) ? unitMask_c : curMask;

  rpcsl_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmrLoad_c),
    .loadVal  (tmrLoadVal_c),
    .cnt      (tmrCnt),
    .isZero_c (tmrZero_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_rdy  <= 1'b1;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      curMask  <= '0;
      rpDPR    <= '0;
      rpMOL    <= '0;
      rpWRL    <= '0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= reject_c;
      case (state)
        ST_IDLE: begin
          if (mountOk_c) begin
            state   <= ST_SPINUP;
            cmd_rdy <= 1'b0;
            busy    <= 1'b1;
            curMask <= unitMask_c;
            rpDPR   <= rpDPR | unitMask_c;
          end else if (unmountOk_c) begin
            state   <= ST_SPINDN;
            cmd_rdy <= 1'b0;
            busy    <= 1'b1;
            curMask <= unitMask_c;
            rpMOL   <= rpMOL & ~unitMask_c;
          end else if (wrlOk_c) begin
            cmd_done <= 1'b1;
            rpWRL    <= (op_c == OP_WRL_SET) ? (rpWRL | unitMask_c) : (rpWRL & ~unitMask_c);
          end
        end
        ST_SPINUP, ST_SPINDN: begin
          if (tmrZero_c) begin
            state   <= ST_IDLE;
            cmd_rdy <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cmd_rdy <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
      if (finUp_c) begin
        cmd_done <= 1'b1;
        rpMOL    <= rpMOL | finMask_c;
      end
      if (finDn_c) begin
        cmd_done <= 1'b1;
        rpDPR    <= rpDPR & ~finMask_c;
        rpWRL    <= rpWRL & ~finMask_c;
      end
    end
  end

`ifdef RPCSL_DEBUG_EN
  // Snapshot holds until the next request re-captures it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_vld  <= 1'b0;
      dbg_data <= '0;
    end else if (dbg_req) begin
      dbg_vld  <= 1'b1;
      dbg_data <= rpDEBUG;
    end
  end
`else
  logic unusedDbg;
  assign unusedDbg = ^{dbg_req, rpDEBUG};
  assign dbg_vld   = 1'b0;
  assign dbg_data  = '0;
`endif

endmodule

// File: tb/tb_rpcsl_mount_seq.sv
// Scoreboard bench for rpcsl_mount_seq: expected completions queued at issue, checked on done/err.
module tb_rpcsl_mount_seq;
  import rpcsl_pkg::*;

  localparam int unsigned NDRV = 8;
  localparam int unsigned SPINUP = 10;
  localparam int unsigned SPINDN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_unit = 3'd0;
  logic        cmd_done;
  logic        cmd_err;
  logic        busy;
  logic [7:0]  rpDPR;
  logic [7:0]  rpMOL;
  logic [7:0]  rpWRL;
  logic [0:63] rpDEBUG = '0;
  logic        dbg_req = 1'b0;
  logic        dbg_vld;
  logic [0:63] dbg_data;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] dpr;
    logic [7:0] mol;
    logic [7:0] wrl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   nAsserts = 0;
  int   nFails = 0;

  rpcsl_mount_seq #(
    .NDRV(NDRV), .SPINUP_CYC(SPINUP), .SPINDN_CYC(SPINDN), .TW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_unit(cmd_unit), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .busy(busy), .rpDPR(rpDPR), .rpMOL(rpMOL), .rpWRL(rpWRL),
    .rpDEBUG(rpDEBUG), .dbg_req(dbg_req), .dbg_vld(dbg_vld), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nAsserts++;
    if (obs !== expv) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Completion monitor: every done/err pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (cmd_done || cmd_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {62'd0, cmd_done, cmd_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("pulse_err", 64'(cmd_err), 64'(e.err));
        check("pulse_done", 64'(cmd_done), 64'(!e.err));
        check("pulse_dpr", 64'(rpDPR), 64'(e.dpr));
        check("pulse_mol", 64'(rpMOL), 64'(e.mol));
        check("pulse_wrl", 64'(rpWRL), 64'(e.wrl));
      end
    end
  end

  // Drive one command for one cycle; lat==0 means no completion is expected
  task automatic issue(input rpcsl_op_t op, input logic [2:0] unit, input bit err, input int lat,
                       input logic [7:0] eD, input logic [7:0] eM, input logic [7:0] eW);
    exp_t x;
    if (lat > 0) begin
      x = '{cyc: cyc + lat, err: err, dpr: eD, mol: eM, wrl: eW};
      sb.push_back(x);
    end
    cmd_vld  = 1'b1;
    cmd_op   = 2'(op);
    cmd_unit = unit;
    @(posedge clk); #1;
    cmd_vld  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && (sb.size() != 0 || !cmd_rdy); i++) begin
      @(posedge clk); #1;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("idle_rdy", 64'(cmd_rdy), 64'd1);
  endtask

  initial begin
    logic [63:0] dbgA;
    logic [63:0] dbgB;
    dbgA = 64'h0123_4567_89AB_CDEF;
    dbgB = 64'hFEDC_BA98_7654_3210;

    #12;
    check("rst_rdy", 64'(cmd_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dpr", 64'(rpDPR), 64'd0);
    check("rst_mol", 64'(rpMOL), 64'd0);
    check("rst_wrl", 64'(rpWRL), 64'd0);
    check("rst_done_err", {62'd0, cmd_done, cmd_err}, 64'd0);
    check("rst_dbg_vld", 64'(dbg_vld), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mount unit 3 with full spin-up timing
    issue(OP_MOUNT, 3'd3, 1'b0, SPINUP, 8'h08, 8'h08, 8'h00);
    check("m3_a1_dpr", 64'(rpDPR), 64'h08);
    check("m3_a1_mol", 64'(rpMOL), 64'h00);
    check("m3_a1_rdy", 64'(cmd_rdy), 64'd0);
    check("m3_a1_busy", 64'(busy), 64'd1);
    for (int k = 2; k <= 11; k++) begin
      @(posedge clk); #1;
      check("m3_rdy", 64'(cmd_rdy), (k == 11) ? 64'd1 : 64'd0);
      check("m3_mol", 64'(rpMOL), (k >= SPINUP) ? 64'h08 : 64'h00);
    end
    waitDrain();

    // Re-mount, write-lock handling, and rejects
    issue(OP_MOUNT, 3'd3, 1'b1, 1, 8'h08, 8'h08, 8'h00);
    check("rej_busy", 64'(busy), 64'd0);
    issue(OP_WRL_SET, 3'd3, 1'b0, 1, 8'h08, 8'h08, 8'h08);
    issue(OP_WRL_SET, 3'd5, 1'b1, 1, 8'h08, 8'h08, 8'h08);
    issue(OP_WRL_CLR, 3'd3, 1'b0, 1, 8'h08, 8'h08, 8'h00);
    issue(OP_UNMOUNT, 3'd5, 1'b1, 1, 8'h08, 8'h08, 8'h00);
    issue(OP_WRL_SET, 3'd3, 1'b0, 1, 8'h08, 8'h08, 8'h08);
    waitDrain();

    // Unmount unit 3 with spin-down timing
    issue(OP_UNMOUNT, 3'd3, 1'b0, SPINDN, 8'h00, 8'h00, 8'h00);
    check("u3_a1_mol", 64'(rpMOL), 64'h00);
    check("u3_a1_dpr", 64'(rpDPR), 64'h08);
    check("u3_a1_wrl", 64'(rpWRL), 64'h08);
    waitDrain();

    // Mount unit 7, then abort a unit 0 mount with reset
    issue(OP_MOUNT, 3'd7, 1'b0, SPINUP, 8'h80, 8'h80, 8'h00);
    waitDrain();
    issue(OP_MOUNT, 3'd0, 1'b0, 0, 8'h00, 8'h00, 8'h00);
    check("m0_a1_dpr", 64'(rpDPR), 64'h81);
    check("m0_a1_busy", 64'(busy), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_dpr", 64'(rpDPR), 64'd0);
    check("arst_mol", 64'(rpMOL), 64'd0);
    check("arst_wrl", 64'(rpWRL), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rdy", 64'(cmd_rdy), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("post_rst_rdy", 64'(cmd_rdy), 64'd1);
    check("post_rst_mol", 64'(rpMOL), 64'd0);

    // Debug snapshot capture and hold
    rpDEBUG = dbgA;
    dbg_req = 1'b1;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    rpDEBUG = dbgB;
`ifdef RPCSL_DEBUG_EN
    check("dbg_vld", 64'(dbg_vld), 64'd1);
    check("dbg_data", dbg_data, dbgA);
`else
    check("dbg_vld", 64'(dbg_vld), 64'd0);
    check("dbg_data", dbg_data, 64'd0);
`endif
    repeat (2) begin
      @(posedge clk); #1;
    end
`ifdef RPCSL_DEBUG_EN
    check("dbg_hold", dbg_data, dbgA);
`else
    check("dbg_hold", dbg_data, 64'd0);
`endif
    dbg_req = 1'b1;
    @(posedge clk); #1;
    dbg_req = 1'b0;
`ifdef RPCSL_DEBUG_EN
    check("dbg_recap", dbg_data, dbgB);
`else
    check("dbg_recap", 64'(dbg_vld), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
